// File: rtl/pulse_train_generator.sv
// Programmable pulse-train source driven by an ASCII command stream (W/P/N/G/S/C).
// Optional byte echo on tx_byte is built only when PULSE_TRAIN_ECHO_EN is defined.
`timescale 1ns/1ps
module pulse_train_generator #(
    parameter int COUNTER_WIDTH = 32,
    parameter int MAX_DIGITS    = 8
) (
    input  logic                     fast_clock,
    input  logic                     reset,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_byte_valid,
    output logic                     pulse_out,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [COUNTER_WIDTH-1:0] pulses_generated,
    output logic [7:0]               tx_byte,
    output logic                     tx_byte_valid
);

    localparam int DIGIT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LIMIT = DIGIT_W'(MAX_DIGITS);
    localparam int NUM_REGS   = 3;
    localparam int IDX_WIDTH  = 0;
    localparam int IDX_PERIOD = 1;
    localparam int IDX_COUNT  = 2;

    typedef enum logic {IDLE, COLLECT} parse_state_t;
    typedef enum logic [1:0] {TGT_WIDTH = 2'd0, TGT_PERIOD = 2'd1, TGT_COUNT = 2'd2} target_t;

    parse_state_t             r_state, w_state_next;
    target_t                  r_target, w_target_next;
    logic [COUNTER_WIDTH-1:0] r_acc, w_acc_next;
    logic [DIGIT_W-1:0]       r_digits, w_digits_next;
    logic                     w_is_hex;
    logic [3:0]               w_hex_val;
    logic                     w_go, w_stop, w_clear, w_parse_err, w_commit;

    logic [COUNTER_WIDTH-1:0] r_shadow      [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] r_active      [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] w_shadow_next [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] w_active_next [NUM_REGS];

    logic [COUNTER_WIDTH-1:0] r_phase, w_phase_next;
    logic [COUNTER_WIDTH-1:0] r_pulse_num, w_pulse_num_next;
    logic [COUNTER_WIDTH-1:0] r_pulses, w_pulses_next;
    logic                     r_busy, w_busy_next;
    logic                     r_pulse_out, w_pulse_out_next;
    logic                     r_done, w_done_next;
    logic                     r_error;
    logic                     w_wrap, w_cfg_ok, w_start, w_go_err, w_finish;
    logic [COUNTER_WIDTH-1:0] w_width_new, w_period_new;

    always_comb begin
        w_is_hex  = 1'b1;
        w_hex_val = 4'd0;
        if (rx_byte >= "0" && rx_byte <= "9") begin
            w_hex_val = rx_byte[3:0];
        end else if ((rx_byte >= "A" && rx_byte <= "F") || (rx_byte >= "a" && rx_byte <= "f")) begin
            w_hex_val = rx_byte[3:0] + 4'd9;
        end else begin
            w_is_hex = 1'b0;
        end
    end

    always_ff @(posedge fast_clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_target <= TGT_WIDTH;
            r_acc    <= '0;
            r_digits <= '0;
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
            r_acc    <= w_acc_next;
            r_digits <= w_digits_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_acc_next    = r_acc;
        w_digits_next = r_digits;
        w_go          = 1'b0;
        w_stop        = 1'b0;
        w_clear       = 1'b0;
        w_parse_err   = 1'b0;
        w_commit      = 1'b0;
        if (rx_byte_valid) begin
            case (r_state)
                IDLE: begin
                    case (rx_byte)
                        "W", "w", "P", "p", "N", "n": begin
                            w_target_next = (rx_byte == "W" || rx_byte == "w") ? TGT_WIDTH :
                                            (rx_byte == "P" || rx_byte == "p") ? TGT_PERIOD : TGT_COUNT;
                            w_acc_next    = '0;
                            w_digits_next = '0;
                            w_state_next  = COLLECT;
                        end
                        "G", "g":                w_go    = 1'b1;
                        "S", "s":                w_stop  = 1'b1;
                        "C", "c":                w_clear = 1'b1;
                        8'h0D, 8'h0A, 8'h20: ;
                        default:                 w_parse_err = 1'b1;
                    endcase
                end
                COLLECT: begin
                    if (w_is_hex) begin
                        if (r_digits == DIGIT_LIMIT) begin
                            w_parse_err  = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_acc_next    = {r_acc[COUNTER_WIDTH-5:0], w_hex_val};
                            w_digits_next = r_digits + 1'b1;
                        end
                    end else if (rx_byte == 8'h0D) begin
                        w_state_next = IDLE;
                        if (r_digits == '0) w_parse_err = 1'b1;
                        else                w_commit    = 1'b1;
                    end else if (rx_byte != 8'h0A) begin
                        w_parse_err  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Active values follow the shadows while idle (one cycle behind) and only at a period wrap while running.
    assign w_wrap = r_busy && (r_phase == r_active[IDX_PERIOD] - 1'b1);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
            localparam logic [COUNTER_WIDTH-1:0] RESET_VALUE =
                (gi == IDX_WIDTH) ? COUNTER_WIDTH'(1) : (gi == IDX_PERIOD) ? COUNTER_WIDTH'(2) : COUNTER_WIDTH'(0);

            assign w_shadow_next[gi] = (w_commit && (r_target == target_t'(gi))) ? r_acc : r_shadow[gi];
            assign w_active_next[gi] = w_wrap ? w_shadow_next[gi] : (r_busy ? r_active[gi] : r_shadow[gi]);

            always_ff @(posedge fast_clock) begin
                if (reset) begin
                    r_shadow[gi] <= RESET_VALUE;
                    r_active[gi] <= RESET_VALUE;
                end else begin
                    r_shadow[gi] <= w_shadow_next[gi];
                    r_active[gi] <= w_active_next[gi];
                end
            end
        end
    endgenerate

    assign w_width_new  = w_active_next[IDX_WIDTH];
    assign w_period_new = w_active_next[IDX_PERIOD];
    assign w_cfg_ok     = (w_width_new != '0) && (w_width_new < w_period_new);
    assign w_start      = w_go && w_cfg_ok;
    assign w_go_err     = w_go && !w_cfg_ok;
    assign w_finish     = r_busy && (r_active[IDX_COUNT] != '0) &&
                          (r_phase == r_active[IDX_WIDTH] - 1'b1) &&
                          (r_pulse_num >= r_active[IDX_COUNT]);

    always_comb begin
        w_busy_next      = r_busy;
        w_phase_next     = r_phase;
        w_pulse_num_next = r_pulse_num;
        w_pulses_next    = r_pulses;
        w_done_next      = 1'b0;
        if (r_busy) begin
            if (r_phase == '0) w_pulses_next = r_pulses + 1'b1;
            if (w_wrap) begin
                w_phase_next     = '0;
                w_pulse_num_next = r_pulse_num + 1'b1;
            end else begin
                w_phase_next = r_phase + 1'b1;
            end
        end
        if (w_finish) begin
            w_busy_next = 1'b0;
            w_done_next = 1'b1;
        end
        if (w_stop) begin
            w_busy_next   = 1'b0;
            w_done_next   = 1'b0;
            w_pulses_next = r_pulses;
        end
        if (w_start) begin
            w_busy_next      = 1'b1;
            w_phase_next     = '0;
            w_pulse_num_next = COUNTER_WIDTH'(1);
            w_pulses_next    = '0;
            w_done_next      = 1'b0;
        end
        w_pulse_out_next = w_busy_next && (w_phase_next < w_width_new);
    end

    always_ff @(posedge fast_clock) begin
        if (reset) begin
            r_phase     <= '0;
            r_pulse_num <= '0;
            r_pulses    <= '0;
            r_busy      <= 1'b0;
            r_pulse_out <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            r_pulse_num <= w_pulse_num_next;
            r_pulses    <= w_pulses_next;
            r_busy      <= w_busy_next;
            r_pulse_out <= w_pulse_out_next;
            r_done      <= w_done_next;
            if (w_clear)                       r_error <= 1'b0;
            else if (w_parse_err || w_go_err)  r_error <= 1'b1;
        end
    end

    assign pulse_out        = r_pulse_out;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;
    assign pulses_generated = r_pulses;

`ifdef PULSE_TRAIN_ECHO_EN
    logic [7:0] r_tx_byte;
    logic       r_tx_valid;
    logic       r_lf_pending;

    // A UART cannot deliver a byte on the cycle right after another, so the trailing LF never collides.
    always_ff @(posedge fast_clock) begin
        if (reset) begin
            r_tx_byte    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_lf_pending <= 1'b0;
        end else begin
            r_tx_valid   <= 1'b0;
            r_lf_pending <= 1'b0;
            if (rx_byte_valid) begin
                r_tx_valid   <= 1'b1;
                r_tx_byte    <= (w_parse_err || w_go_err) ? 8'h3F : rx_byte;
                r_lf_pending <= w_commit;
            end else if (r_lf_pending) begin
                r_tx_valid <= 1'b1;
                r_tx_byte  <= 8'h0A;
            end
        end
    end

    assign tx_byte       = r_tx_byte;
    assign tx_byte_valid = r_tx_valid;
`else
    assign tx_byte       = 8'h00;
    assign tx_byte_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: per-cycle pulse/busy/done expectations are queued
// when a train is launched and popped on each falling clock edge.
`timescale 1ns/1ps
module tb_pulse_train_generator;
    localparam int CW = 32;

    logic          fast_clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic          pulse_out, busy, done, error;
    logic [CW-1:0] pulses_generated;
    logic [7:0]    tx_byte;
    logic          tx_byte_valid;

    pulse_train_generator #(.COUNTER_WIDTH(CW), .MAX_DIGITS(8)) dut (
        .fast_clock       (fast_clock),
        .reset            (reset),
        .rx_byte          (rx_byte),
        .rx_byte_valid    (rx_byte_valid),
        .pulse_out        (pulse_out),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .pulses_generated (pulses_generated),
        .tx_byte          (tx_byte),
        .tx_byte_valid    (tx_byte_valid)
    );

    always #5 fast_clock = ~fast_clock;

    typedef struct packed { logic p; logic b; logic d; } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic p, input logic b, input logic d);
        exp_t e;
        e.p = p;
        e.b = b;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // One cycle: compare any queued expectation at the falling edge, then drive the next input.
    task automatic step(input logic v, input logic [7:0] b);
        exp_t e;
        @(negedge fast_clock);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pulse_out", pulse_out, e.p);
            chk("busy", busy, e.b);
            chk("done", done, e.d);
        end
        rx_byte_valid = v;
        rx_byte       = b;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            $display("rx byte 0x%02h", s[i]);
            step(1'b1, s[i]);
            step(1'b0, 8'h00);
`ifndef PULSE_TRAIN_ECHO_EN
            chk("tx_byte_valid_off", tx_byte_valid, 0);
`endif
            step(1'b0, 8'h00);
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step(1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] b;
        logic       v;
        reset = 1'b1;
        rx_byte = 8'h00;
        rx_byte_valid = 1'b0;
        repeat (3) @(negedge fast_clock);
        chk("rst_pulse_out", pulse_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_pulses", pulses_generated, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_valid", tx_byte_valid, 0);
        reset = 1'b0;

        // Finite train: 3 high / 5 low, four pulses.
        send("W3\015");
        send("P8\015");
        send("N4\015");
        step(1'b1, "G");
        for (int k = 1; k <= 4; k++) begin
            for (int ph = 0; ph < 8; ph++) begin
                if (ph < 3)      push(1'b1, 1'b1, 1'b0);
                else if (k < 4)  push(1'b0, 1'b1, 1'b0);
                else if (ph == 3) push(1'b0, 1'b0, 1'b1);
                else             push(1'b0, 1'b0, 1'b0);
            end
        end
        drain();
        chk("finite_pulses", pulses_generated, 4);
        chk("finite_error", error, 0);

        // Continuous train, stopped after 96 cycles.
        send("N0\015");
        step(1'b1, "G");
        for (int j = 0; j < 96; j++) push((j % 8) < 3, 1'b1, 1'b0);
        repeat (3) push(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 99; i++) step(i == 96, (i == 96) ? 8'h53 : 8'h00);
        chk("stop_pulses", pulses_generated, 12);
        step(1'b0, 8'h00);
        chk("stop_pulses_hold", pulses_generated, 12);

        // Width change mid-period, then a commit landing exactly on a wrap.
        step(1'b1, "G");
        for (int j = 0; j < 32; j++) push((j % 8) < ((j >= 8 && j < 24) ? 5 : 3), 1'b1, 1'b0);
        repeat (2) push(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 34; i++) begin
            v = 1'b1;
            case (i)
                1, 20:   b = "W";
                2:       b = "5";
                22:      b = "3";
                3, 24:   b = 8'h0D;
                32:      b = "S";
                default: begin v = 1'b0; b = 8'h00; end
            endcase
            step(v, b);
        end
        chk("shadow_error", error, 0);

        // Invalid configuration rejected at go.
        send("W8\015");
        send("P8\015");
        send("G");
        chk("cfg_error", error, 1);
        chk("cfg_busy", busy, 0);
        chk("cfg_pulse_out", pulse_out, 0);
        send("C");
        chk("cfg_clear", error, 0);
        send("W3\015");

        // Parse errors leave the active registers untouched.
        send("W12345678");
        chk("eight_digits_ok", error, 0);
        send("9");
        chk("ninth_digit_error", error, 1);
        send("C");
        chk("clear_after_digits", error, 0);
        send("Wz");
        chk("bad_char_error", error, 1);
        send("C");
        send("P\015");
        chk("empty_arg_error", error, 1);
        send("C");
        chk("clear_after_empty", error, 0);
        send("N2\015");
        step(1'b1, "G");
        for (int j = 0; j < 11; j++) push((j % 8) < 3, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1);
        push(1'b0, 1'b0, 1'b0);
        drain();
        chk("after_errors_pulses", pulses_generated, 2);

        // Reset in the middle of a high phase restores defaults (width 1, period 2, count 0).
        send("N0\015");
        step(1'b1, "G");
        push(1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b0);
        drain();
        reset = 1'b1;
        @(negedge fast_clock);
        chk("midrst_pulse_out", pulse_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pulses", pulses_generated, 0);
        chk("midrst_tx_valid", tx_byte_valid, 0);
        reset = 1'b0;
        step(1'b1, "G");
        for (int j = 0; j < 6; j++) push((j % 2) == 0, 1'b1, 1'b0);
        repeat (2) push(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(i == 6, (i == 6) ? 8'h53 : 8'h00);
        chk("default_cfg_pulses", pulses_generated, 3);

`ifdef PULSE_TRAIN_ECHO_EN
        step(1'b1, "W");
        step(1'b0, 8'h00);
        chk("echo_w_valid", tx_byte_valid, 1);
        chk("echo_w", tx_byte, 8'h57);
        step(1'b1, "1");
        step(1'b0, 8'h00);
        chk("echo_1", tx_byte, 8'h31);
        step(1'b1, 8'h0D);
        step(1'b0, 8'h00);
        chk("echo_cr_valid", tx_byte_valid, 1);
        chk("echo_cr", tx_byte, 8'h0D);
        step(1'b0, 8'h00);
        chk("echo_lf_valid", tx_byte_valid, 1);
        chk("echo_lf", tx_byte, 8'h0A);
        step(1'b0, 8'h00);
        chk("echo_idle", tx_byte_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
